// File: rtl/conv_stream_controller_pkg.sv
// conv_ctrl_pkg: shared constants, state encoding and sizing helpers for the conv stream controller
package conv_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  function automatic int conv_latency(input int k);
    return 1 + $clog2(k * k + 1);
  endfunction
  function automatic int pipe_depth(input int k);
    return conv_latency(k) + 1;
  endfunction
  function automatic int out_dim(input int img, input int k);
    return img - k + 1;
  endfunction
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/conv_stream_controller_if.sv
// conv_stream_controller_if: control, pixel and result handshake bundle of the conv stream controller
interface conv_stream_controller_if #(parameter int ROW_W = 5, parameter int COL_W = 5);
  logic start;
  logic busy;
  logic done;
  logic in_valid;
  logic in_ready;
  logic lb_shift;
  logic conv_enable;
  logic out_valid;
  logic out_ready;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  modport master (output start, in_valid, out_ready,
                  input busy, done, in_ready, lb_shift, conv_enable, out_valid, out_row, out_col);
  modport slave (input start, in_valid, out_ready,
                 output busy, done, in_ready, lb_shift, conv_enable, out_valid, out_row, out_col);
endinterface

// File: rtl/conv_stream_controller_valid_delay_line.sv
// valid_delay_line: enable-gated 1-bit shift register tracking valid slots through the datapath
module valid_delay_line #(parameter int DEPTH = 7) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] v;
  // shift one slot per enabled cycle; a frozen pipeline holds its valid bits
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) v <= '0;
    else if (enable) v <= {v[DEPTH-2:0], din};
  assign dout = v[DEPTH-1];
endmodule

// File: rtl/conv_stream_controller.sv
// conv_stream_controller: sequences one frame through line buffer and convolution pipeline with backpressure
module conv_stream_controller
  import conv_ctrl_pkg::*;
#(
  parameter int KERNEL_SIZE = 5,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input logic clock,
  input logic resetn,
  conv_stream_controller_if.slave bus
);
  localparam int K     = KERNEL_SIZE;
  localparam int OUT_W = out_dim(IMG_WIDTH, K);
  localparam int OUT_H = out_dim(IMG_HEIGHT, K);
  localparam int PD    = pipe_depth(K);
  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int NOUT  = OUT_W * OUT_H;
  localparam int CW    = cnt_w(IMG_WIDTH);
  localparam int RW    = cnt_w(IMG_HEIGHT);
  localparam int OCW   = cnt_w(OUT_W);
  localparam int ORW   = cnt_w(OUT_H);
  localparam int PW    = $clog2(NPIX) + 1;
  localparam int QW    = $clog2(NOUT) + 1;
  state_t state, state_n;
  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic [PW-1:0] pix_cnt;
  logic [OCW-1:0] out_col;
  logic [ORW-1:0] out_row;
  logic [QW-1:0] out_cnt;
  logic stall, accept, deliver, win;
  assign stall           = bus.out_valid && !bus.out_ready;
  assign bus.conv_enable = !stall;
  assign bus.in_ready    = (state == RUN) && bus.conv_enable && (pix_cnt < PW'(NPIX));
  assign accept          = bus.in_valid && bus.in_ready;
  assign bus.lb_shift    = accept;
  assign deliver         = bus.out_valid && bus.out_ready;
  assign win             = accept && (in_row >= RW'(K - 1)) && (in_col >= CW'(K - 1));
  assign bus.busy        = (state == RUN) || (state == FLUSH);
  assign bus.done        = (state == DONE);
  assign bus.out_row     = out_row;
  assign bus.out_col     = out_col;
  valid_delay_line #(.DEPTH(PD)) u_vdl (
    .clock  (clock),
    .resetn (resetn),
    .enable (bus.conv_enable),
    .din    (win),
    .dout   (bus.out_valid)
  );
  // state register
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  // next state: start leaves IDLE, last accept enters FLUSH, last delivery enters DONE
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && bus.start) ? RUN :
              (state == RUN && accept && pix_cnt == PW'(NPIX - 1)) ? FLUSH :
              (state == FLUSH && deliver && out_cnt == QW'(NOUT - 1)) ? DONE :
              (state == DONE) ? IDLE : state;
  end
  // input and output position counters, cleared when a frame starts
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      in_col <= '0; in_row <= '0; pix_cnt <= '0;
      out_col <= '0; out_row <= '0; out_cnt <= '0;
    end else if (state == IDLE && bus.start) begin
      in_col <= '0; in_row <= '0; pix_cnt <= '0;
      out_col <= '0; out_row <= '0; out_cnt <= '0;
    end else begin
      if (accept) begin
        in_col  <= (in_col == CW'(IMG_WIDTH - 1)) ? '0 : in_col + 1'b1;
        in_row  <= (in_col == CW'(IMG_WIDTH - 1)) ? in_row + 1'b1 : in_row;
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (deliver) begin
        out_col <= (out_col == OCW'(OUT_W - 1)) ? '0 : out_col + 1'b1;
        out_row <= (out_col == OCW'(OUT_W - 1)) ? out_row + 1'b1 : out_row;
        out_cnt <= out_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_conv_stream_controller.sv
// tb_conv_stream_controller: directed frame-level checks of the conv stream controller (K=5, 28x28)
module tb_conv_stream_controller;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int tests = 0, fails = 0;
  bit mon_en = 1'b0;
  int cyc, n_acc, n_out, n_done, acc_cyc, first_cyc, last_cyc, done_cyc, er, ec, last_r, last_c;
  bit prev_stall;
  int prev_row, prev_col;
  conv_stream_controller_if #(.ROW_W(5), .COL_W(5)) bus ();
  conv_stream_controller #(.KERNEL_SIZE(5), .IMG_WIDTH(28), .IMG_HEIGHT(28)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_rst(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
    chk({tag, "_lb_shift"}, int'(bus.lb_shift), 0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_row"}, int'(bus.out_row), 0);
    chk({tag, "_out_col"}, int'(bus.out_col), 0);
    chk({tag, "_conv_enable"}, int'(bus.conv_enable), 1);
  endtask
  task automatic clear_mon();
    cyc = 0; n_acc = 0; n_out = 0; n_done = 0; acc_cyc = -1; first_cyc = -1;
    last_cyc = -1; done_cyc = -1; er = 0; ec = 0; last_r = -1; last_c = -1;
    prev_stall = 1'b0; prev_row = 0; prev_col = 0;
  endtask
  // observe handshakes mid-cycle, against an independent row/col model of the output order
  always @(negedge clock) if (mon_en) begin
    cyc++;
    if (bus.lb_shift) begin
      n_acc++;
      if (n_acc == 4 * 28 + 4 + 1) acc_cyc = cyc;
    end
    if (bus.out_valid && first_cyc < 0) first_cyc = cyc;
    if (prev_stall) begin
      chk("held_valid", int'(bus.out_valid), 1);
      chk("held_row", int'(bus.out_row), prev_row);
      chk("held_col", int'(bus.out_col), prev_col);
    end
    if (bus.out_valid && !bus.out_ready)
      chk("stall_gate", int'({bus.conv_enable, bus.in_ready}), 0);
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_row = int'(bus.out_row);
    prev_col = int'(bus.out_col);
    if (bus.out_valid && bus.out_ready) begin
      chk("out_row", int'(bus.out_row), er);
      chk("out_col", int'(bus.out_col), ec);
      n_out++; last_cyc = cyc; last_r = er; last_c = ec;
      if (ec == 23) begin ec = 0; er++; end
      else ec++;
    end
    if (bus.done) begin n_done++; done_cyc = cyc; end
  end
  task automatic run_frame(input bit toggle, input bit stall_first, input bit hold_last, input bit poke);
    int stall_left = 0, hold_left = 0, c = 0, tail = 0;
    bit stalled = 1'b0, held = 1'b0, poked = 1'b0;
    clear_mon();
    mon_en = 1'b1;
    bus.start = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    while (c < 6000 && tail < 4) begin
      bus.in_valid = toggle ? (c[0] == 1'b0) : 1'b1;
      if (poke && !poked && n_acc == 784 && bus.busy) begin
        bus.start = 1'b1; poked = 1'b1;
      end else bus.start = poke && c == 200;
      if (stall_first && !stalled && bus.out_valid) begin stall_left = 10; stalled = 1'b1; end
      if (hold_last && !held && bus.out_valid && n_out == 575) begin hold_left = 5; held = 1'b1; end
      bus.out_ready = (stall_left == 0) && (hold_left == 0);
      if (hold_left > 0) chk("flush_hold_busy_notdone", int'({bus.busy, bus.done}), 2);
      if (stall_left > 0) stall_left--;
      if (hold_left > 0) hold_left--;
      @(posedge clock); #1;
      c++;
      if (n_done > 0) tail++;
    end
    mon_en = 1'b0;
    bus.in_valid = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b1;
    chk("frame_in_budget", int'(c < 6000), 1);
    chk("accepts", n_acc, 784);
    chk("deliveries", n_out, 576);
    chk("done_pulses", n_done, 1);
    chk("first_latency", first_cyc - acc_cyc, 7);
    chk("last_row", last_r, 23);
    chk("last_col", last_c, 23);
    chk("done_after_last", done_cyc - last_cyc, 1);
    if (stall_first) chk("stall_applied", int'(stalled), 1);
    if (hold_last) chk("hold_applied", int'(held), 1);
    chk("idle_after", int'(bus.busy), 0);
  endtask
  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    clear_mon();
    #1;
    check_rst("reset");
    #20;
    @(posedge clock); #1;
    resetn = 1'b1;
    check_rst("post_reset");
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    clear_mon();
    mon_en = 1'b1;
    bus.start = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 1000 && n_acc < 300; i++) begin
      @(posedge clock); #1;
    end
    chk("reach_pixel_300", n_acc, 300);
    chk("busy_mid_run", int'(bus.busy), 1);
    mon_en = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check_rst("async_reset");
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    chk("idle_after_reset", int'(bus.busy), 0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(1'b0, 1'b0, 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
